exp_align_pipe: RTL and testbench
=================================

Name: exp_align_pipe

Overview:
- Pipelined, parametrised exponent-compare and mantissa-alignment stage for the IEEE754 add/sub datapath.
- Takes two operand exponents and hidden-bit mantissas and orders them by magnitude. It computes the exponent difference, flags shifts that are too large, and right-shifts the smaller mantissa into a guard/round/sticky-extended field.
- Sits between operand unpack and the mantissa adder. Uses a 2-stage valid/ready pipeline with a tag passthrough.

Parameters:
- EXP_W, 8, exponent width in bits.
- MAN_W, 24, mantissa width including hidden bit.
- SHIFT_W, 5, width of the reported shift amount; must satisfy 2^SHIFT_W > MAN_W.
- TAG_W, 4, width of the opaque sideband tag carried with each operation.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept this cycle
- in_exp_a  in  EXP_W  exponent A
- in_man_a  in  MAN_W  mantissa A
- in_exp_b  in  EXP_W  exponent B
- in_man_b  in  MAN_W  mantissa B
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_exp  out  EXP_W  larger exponent
- out_man_big  out  MAN_W+3  larger-magnitude mantissa followed by 3'b000
- out_man_small  out  MAN_W+3  aligned smaller mantissa with G, R, S in the low bits
- out_swap  out  1  1 = operand B is the larger
- out_too_large  out  1  exponent difference > MAN_W
- out_shift  out  SHIFT_W  applied shift; 0 when too_large
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: one clock, clk; rst is asynchronous and active-high.
  - While rst is high, both stage valid bits are 0 and all output data registers are 0.
  - Therefore out_valid=0 and in_ready=1 after reset.
  - Reset asserted mid-operation discards all in-flight operations immediately, with no partial output.
- Stage 1 registers on acceptance (in_valid && in_ready):
  - d = {1'b0,exp_a} - {1'b0,exp_b}, computed in EXP_W+1 bits; |d| is its magnitude.
  - swap = (exp_a < exp_b) || (exp_a == exp_b && man_a < man_b). Equal mantissas give swap=0.
  - Registered fields: big exp/man, small man, |d|, too_large = (|d| > MAN_W), tag.
- Stage 2 registers when stage 1 advances:
  - ext = {small_man, 3'b000}.
  - If too_large: out_man_small = {MAN_W+2 zeros, |small_man|}, i.e. sticky only; out_shift = 0.
  - Otherwise: out_man_small = ext >> |d|, with bit 0 ORed with the OR of every bit shifted out (sticky); out_shift = |d|[SHIFT_W-1:0].
  - out_man_big = {big_man, 3'b000}.
- Latency: exactly 2 cycles from acceptance to out_valid when unstalled. Throughput is 1 operation per cycle.
- Handshake:
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances when !s1_valid || (stage 2 advances).
  - in_ready = stage-1 advance condition.
  - in_ready may depend combinationally on out_ready. There is no combinational path from any in_* data to out_*.
- Output stability: while out_valid && !out_ready, all out_* hold stable. No operation is dropped or duplicated, and ordering is preserved.
- flush:
  - Clears both valid bits at the next edge. Data registers need not clear.
  - An input presented in the same cycle as flush is not accepted (in_ready=0 while flush=1).
- Simultaneous events: output consumed and new input accepted in the same cycle is legal and keeps full throughput.
- Boundary cases:
  - exp_a == exp_b → shift 0.
  - |d| == MAN_W → not too_large; only sticky/round may be nonzero.
  - |d| == MAN_W+1 → too_large.
  - Zero mantissas are legal, and their sticky = 0.

Test Plan (EXP_W=8, MAN_W=24):
- Basic alignment: exp_a=0x85, man_a=0xC00000, exp_b=0x82, man_b=0x800000 → after 2 cycles: out_exp=0x85, swap=0, shift=3, big=0x6000000, small=0x0800000, too_large=0.
- Sticky: exp_a=0x85, man_a=0xC00000, exp_b=0x80, man_b=0x800001 → shift=5, small=0x0200001.
- Swap on exponent and on mantissa:
  - exp_a=0x10, exp_b=0x20 → swap=1, out_exp=0x20, shift=16.
  - exp_a=exp_b=0x7F, man_a=0x900000, man_b=0xA00000 → swap=1, shift=0, big=0x5000000.
- Too large: exp_a=0x9E, exp_b=0x80, man_b=0x800000 → too_large=1, shift=0, small=0x0000001. Also |d|=24 → too_large=0, shift=24, small=0x0000004.
- Backpressure: 4 back-to-back inputs with out_ready=0 for 5 cycles → in_ready falls after 2 accepted, outputs stable. Then out_ready=1 → all 4 tags emerge in order with no gaps.
- Flush/reset: flush with 2 in flight → out_valid=0 next cycle and no stale output. Assert rst asynchronously mid-stall → out_valid drops before the next edge, and in_ready=1.

Source files
------------

// File: rtl/exp_align_pipe.sv
// exp_align_pipe: two-stage exponent compare and mantissa alignment for the
// floating-point add/sub datapath.
//
// Stage 1 orders the operands by magnitude, takes the exponent difference and
// flags differences too large to align. Stage 2 right-shifts the smaller
// mantissa into a guard/round/sticky extended field.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   flush           synchronous clear of both pipeline valid bits
//   in_valid/ready  upstream handshake
//   in_exp_a/b      operand exponents
//   in_man_a/b      operand mantissas including hidden bit
//   in_tag          opaque sideband tag
//   out_valid/ready downstream handshake
//   out_exp         larger exponent
//   out_man_big     larger-magnitude mantissa followed by 3'b000
//   out_man_small   aligned smaller mantissa, G/R/S in the low three bits
//   out_swap        1 when operand B is the larger
//   out_too_large   exponent difference exceeds MAN_W
//   out_shift       applied shift amount (0 when too large)
//   out_tag         tag of this result
module exp_align_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 24,
  parameter int SHIFT_W = 5,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   in_exp_a,
  input  logic [MAN_W-1:0]   in_man_a,
  input  logic [EXP_W-1:0]   in_exp_b,
  input  logic [MAN_W-1:0]   in_man_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MAN_W+2:0]   out_man_big,
  output logic [MAN_W+2:0]   out_man_small,
  output logic               out_swap,
  output logic               out_too_large,
  output logic [SHIFT_W-1:0] out_shift,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int EXT_W = MAN_W + 3;
  localparam logic [EXP_W:0] MAN_W_D = (EXP_W+1)'(MAN_W);

  // Handshake
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !flush;
  assign out_valid = s2_valid;

  // Stage 1 combinational: compare and difference
  logic [EXP_W:0] diff;
  logic [EXP_W:0] abs_d;
  logic           swap_c;

  assign diff   = {1'b0, in_exp_a} - {1'b0, in_exp_b};
  assign abs_d  = diff[EXP_W] ? -diff : diff;
  assign swap_c = (in_exp_a < in_exp_b) ||
                  ((in_exp_a == in_exp_b) && (in_man_a < in_man_b));

  // Stage 1 registers. Only the low SHIFT_W bits of |d| are kept: whenever the
  // shift is actually applied |d| <= MAN_W < 2^SHIFT_W, so nothing is lost.
  logic [EXP_W-1:0]   s1_exp;
  logic [MAN_W-1:0]   s1_big_man;
  logic [MAN_W-1:0]   s1_small_man;
  logic [SHIFT_W-1:0] s1_shift;
  logic               s1_too_large;
  logic               s1_swap;
  logic [TAG_W-1:0]   s1_tag;

  // Stage 2 combinational: align with sticky collection
  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] lost_mask;
  logic             sticky_c;
  logic [EXT_W-1:0] small_c;

  assign ext       = {s1_small_man, 3'b000};
  assign shifted   = ext >> s1_shift;
  // Ones in exactly the bit positions that fall off the bottom of the shift.
  assign lost_mask = ~({EXT_W{1'b1}} << s1_shift);
  assign sticky_c  = |(ext & lost_mask);

  always_comb begin
    small_c = '0;
    if (s1_too_large) begin
      small_c[0] = |s1_small_man;
    end else begin
      small_c    = shifted;
      small_c[0] = shifted[0] | sticky_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_exp        <= '0;
      s1_big_man    <= '0;
      s1_small_man  <= '0;
      s1_shift      <= '0;
      s1_too_large  <= 1'b0;
      s1_swap       <= 1'b0;
      s1_tag        <= '0;
      s2_valid      <= 1'b0;
      out_exp       <= '0;
      out_man_big   <= '0;
      out_man_small <= '0;
      out_swap      <= 1'b0;
      out_too_large <= 1'b0;
      out_shift     <= '0;
      out_tag       <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_exp       <= swap_c ? in_exp_b : in_exp_a;
          s1_big_man   <= swap_c ? in_man_b : in_man_a;
          s1_small_man <= swap_c ? in_man_a : in_man_b;
          s1_shift     <= abs_d[SHIFT_W-1:0];
          s1_too_large <= (abs_d > MAN_W_D);
          s1_swap      <= swap_c;
          s1_tag       <= in_tag;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_exp       <= s1_exp;
          out_man_big   <= {s1_big_man, 3'b000};
          out_man_small <= small_c;
          out_swap      <= s1_swap;
          out_too_large <= s1_too_large;
          out_shift     <= s1_too_large ? '0 : s1_shift;
          out_tag       <= s1_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_exp_align_pipe.sv
module tb_exp_align_pipe;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 24;
  localparam int SHIFT_W = 5;
  localparam int TAG_W   = 4;

  typedef struct packed {
    logic [7:0]  ex;
    logic [26:0] bg;
    logic [26:0] sml;
    logic        swap;
    logic        tl;
    logic [4:0]  shift;
    logic [3:0]  tag;
  } res_t;

  typedef struct packed {
    logic [7:0]  ea;
    logic [23:0] ma;
    logic [7:0]  eb;
    logic [23:0] mb;
    logic [3:0]  tag;
  } in_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [EXP_W-1:0]   in_exp_a, in_exp_b;
  logic [MAN_W-1:0]   in_man_a, in_man_b;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [EXP_W-1:0]   out_exp;
  logic [MAN_W+2:0]   out_man_big, out_man_small;
  logic               out_swap, out_too_large;
  logic [SHIFT_W-1:0] out_shift;
  logic [TAG_W-1:0]   out_tag;

  int vectors = 0;
  int miscompares = 0;
  bit fired;
  in_t  in_q[$];
  res_t exp_q[$];

  always #5 clk = ~clk;

  exp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_exp_a(in_exp_a), .in_man_a(in_man_a),
    .in_exp_b(in_exp_b), .in_man_b(in_man_b),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_man_big(out_man_big), .out_man_small(out_man_small),
    .out_swap(out_swap), .out_too_large(out_too_large),
    .out_shift(out_shift), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  function automatic res_t observe();
    res_t r;
    r.ex = out_exp; r.bg = out_man_big; r.sml = out_man_small;
    r.swap = out_swap; r.tl = out_too_large; r.shift = out_shift; r.tag = out_tag;
    return r;
  endfunction

  // Reference: plain arithmetic on the operand values.
  function automatic res_t model(input in_t i);
    res_t r;
    bit sw;
    int d, ad;
    longint unsigned big_m, small_m, ext, aligned;
    sw = (i.ea < i.eb) || (i.ea == i.eb && i.ma < i.mb);
    d  = int'(i.ea) - int'(i.eb);
    ad = (d < 0) ? -d : d;
    big_m   = sw ? 64'(i.mb) : 64'(i.ma);
    small_m = sw ? 64'(i.ma) : 64'(i.mb);
    r.ex  = sw ? i.eb : i.ea;
    r.bg  = 27'(big_m * 8);
    r.swap = sw;
    r.tag = i.tag;
    ext = small_m * 8;
    if (ad > MAN_W) begin
      r.tl = 1'b1;
      r.shift = 5'd0;
      r.sml = (small_m != 0) ? 27'd1 : 27'd0;
    end else begin
      r.tl = 1'b0;
      r.shift = 5'(ad);
      aligned = ext / (64'd1 << ad);
      if ((ext % (64'd1 << ad)) != 0) aligned = aligned | 64'd1;
      r.sml = 27'(aligned);
    end
    return r;
  endfunction

  function automatic logic [23:0] rand_man();
    case ($urandom_range(0, 7))
      0:       return 24'd0;
      1:       return 24'($urandom);
      default: return {1'b1, 23'($urandom)};
    endcase
  endfunction

  function automatic in_t rand_in(input logic [3:0] tag);
    in_t r;
    int e2;
    r.ea = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 3))
      0: r.eb = 8'($urandom_range(0, 255));
      1: r.eb = r.ea;
      default: begin
        e2 = int'(r.ea) + int'($urandom_range(0, 60)) - 30;
        if (e2 < 0) e2 = 0;
        if (e2 > 255) e2 = 255;
        r.eb = 8'(e2);
      end
    endcase
    r.ma = rand_man();
    r.mb = rand_man();
    if ($urandom_range(0, 7) == 0) r.mb = r.ma;
    r.tag = tag;
    return r;
  endfunction

  // One clock: drive at the falling edge, sample 1 time unit later.
  task automatic tick(input bit rdy);
    @(negedge clk);
    out_ready = rdy;
    if (in_q.size() != 0) begin
      in_valid = 1'b1;
      in_exp_a = in_q[0].ea; in_man_a = in_q[0].ma;
      in_exp_b = in_q[0].eb; in_man_b = in_q[0].mb;
      in_tag   = in_q[0].tag;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    fired = 1'b0;
    if (out_ready) begin
      if (exp_q.size() == 0) check("idle_out_valid", out_valid, 0);
      else if (out_valid) begin
        check("result", observe(), exp_q.pop_front());
        fired = 1'b1;
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(in_q.pop_front()));
  endtask

  task automatic directed(input string name, input logic [7:0] ea, input logic [23:0] ma,
                          input logic [7:0] eb, input logic [23:0] mb, input res_t expv);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_exp_a = ea; in_man_a = ma; in_exp_b = eb; in_man_b = mb; in_tag = expv.tag;
    #1;
    check({name, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({name, "_lat1"}, out_valid, 0);
    @(negedge clk);
    #1;
    check({name, "_valid"}, out_valid, 1);
    check(name, observe(), expv);
  endtask

  initial begin
    res_t held;
    int nfire;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_exp_a = '0; in_exp_b = '0; in_man_a = '0; in_man_b = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", observe(), 0);

    directed("basic",   8'h85, 24'hC00000, 8'h82, 24'h800000,
             '{ex:8'h85, bg:27'h6000000, sml:27'h0800000, swap:1'b0, tl:1'b0, shift:5'd3, tag:4'd1});
    directed("sticky",  8'h85, 24'hC00000, 8'h80, 24'h800001,
             '{ex:8'h85, bg:27'h6000000, sml:27'h0200001, swap:1'b0, tl:1'b0, shift:5'd5, tag:4'd2});
    directed("swap_exp", 8'h10, 24'h800000, 8'h20, 24'h800000,
             '{ex:8'h20, bg:27'h4000000, sml:27'h0000400, swap:1'b1, tl:1'b0, shift:5'd16, tag:4'd3});
    directed("swap_man", 8'h7F, 24'h900000, 8'h7F, 24'hA00000,
             '{ex:8'h7F, bg:27'h5000000, sml:27'h4800000, swap:1'b1, tl:1'b0, shift:5'd0, tag:4'd4});
    directed("too_large", 8'h9E, 24'h800000, 8'h80, 24'h800000,
             '{ex:8'h9E, bg:27'h4000000, sml:27'h0000001, swap:1'b0, tl:1'b1, shift:5'd0, tag:4'd5});
    directed("d_eq_man", 8'h98, 24'h800000, 8'h80, 24'h800000,
             '{ex:8'h98, bg:27'h4000000, sml:27'h0000004, swap:1'b0, tl:1'b0, shift:5'd24, tag:4'd6});
    directed("d_man_p1", 8'h99, 24'h800000, 8'h80, 24'h800000,
             '{ex:8'h99, bg:27'h4000000, sml:27'h0000001, swap:1'b0, tl:1'b1, shift:5'd0, tag:4'd7});
    directed("equal",   8'h40, 24'hABCDEF, 8'h40, 24'hABCDEF,
             '{ex:8'h40, bg:27'h55E6F78, sml:27'h55E6F78, swap:1'b0, tl:1'b0, shift:5'd0, tag:4'd8});
    directed("zero_man", 8'h9E, 24'h800000, 8'h80, 24'h000000,
             '{ex:8'h9E, bg:27'h4000000, sml:27'h0000000, swap:1'b0, tl:1'b1, shift:5'd0, tag:4'd9});

    // Backpressure: four back-to-back operations against a stalled output.
    @(negedge clk);
    exp_q.delete(); in_q.delete();
    for (int t = 1; t <= 4; t++) in_q.push_back(rand_in(4'(t)));
    for (int c = 0; c < 5; c++) begin
      tick(1'b0);
      if (c == 2) held = observe();
      if (c >= 2) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold", observe(), held);
      end
    end
    check("bp_accepted", in_q.size(), 2);
    nfire = 0;
    for (int c = 0; c < 4; c++) begin
      tick(1'b1);
      if (fired) nfire++;
    end
    check("bp_no_gap", nfire, 4);
    check("bp_drained", exp_q.size() + in_q.size(), 0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      if (in_q.size() < 2 && $urandom_range(0, 3) != 0) in_q.push_back(rand_in(4'($urandom)));
      tick($urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 40 && (in_q.size() != 0 || exp_q.size() != 0); k++) tick(1'b1);
    check("rand_drain_exp", exp_q.size(), 0);
    check("rand_drain_in", in_q.size(), 0);

    // Flush with two operations in flight.
    for (int t = 0; t < 3; t++) in_q.push_back(rand_in(4'(10 + t)));
    tick(1'b0);
    tick(1'b0);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    in_exp_a = in_q[0].ea; in_man_a = in_q[0].ma;
    in_exp_b = in_q[0].eb; in_man_b = in_q[0].mb; in_tag = in_q[0].tag;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    exp_q.delete(); in_q.delete();
    repeat (4) tick(1'b1);

    // Asynchronous reset in the middle of a stall.
    for (int t = 0; t < 2; t++) in_q.push_back(rand_in(4'(13 + t)));
    tick(1'b0);
    tick(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_data", observe(), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); in_q.delete();
    repeat (4) tick(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
